// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one synchronous ROM read port between the instruction
// fetch channel and a data-side ROM read channel.
//
// One transaction is outstanding at a time. A request is accepted in IDLE, or
// in HOLD on the same cycle the pending response handshakes. Accept at cycle T
// drives the ROM at T. The read data is captured at T+1, and the response is
// valid from T+2. Data wins arbitration unless fetch has waited through
// STARVE_MAX consecutive data grants. An odd address never reaches the ROM
// and returns data 0 with err=1.
//
// Ports
//   clk, rst_n                              clock, async active-low reset
//   if_req_valid/ready/addr                 fetch request
//   if_rsp_valid/ready/data/err             fetch response
//   dm_req_valid/ready/addr                 data ROM read request
//   dm_rsp_valid/ready/data/err             data response
//   mem_en, mem_addr, mem_rdata             shared ROM port (rdata one cycle after en)
//   grant_dm                                owner of the transaction in flight (1 = data)
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | no transaction
// READ  | ROM access issued last cycle, data returns now
// HOLD  | response valid, waiting for the consumer
module imem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_req_addr,
    output logic        if_rsp_valid,
    input  logic        if_rsp_ready,
    output logic [31:0] if_rsp_data,
    output logic        if_rsp_err,
    input  logic        dm_req_valid,
    output logic        dm_req_ready,
    input  logic [31:0] dm_req_addr,
    output logic        dm_rsp_valid,
    input  logic        dm_rsp_ready,
    output logic [31:0] dm_rsp_data,
    output logic        dm_rsp_err,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        grant_dm
);

    localparam int unsigned CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          grant_q, grant_d;
    logic          misal_q, misal_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;

    logic          rsp_hs;
    logic          slot;
    logic          fetch_first;
    logic          pick_if;
    logic          pick_dm;
    logic          accept;
    logic [31:0]   win_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            starve_q    <= '0;
            grant_q     <= 1'b0;
            misal_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            grant_q     <= grant_d;
            misal_q     <= misal_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        grant_d     = grant_q;
        misal_d     = misal_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;

        rsp_hs = rsp_valid_q && (grant_q ? dm_rsp_ready : if_rsp_ready);
        // rst_n gates the accept slot so that req_ready and mem_en read 0
        // while reset is held, even though IDLE would otherwise accept.
        slot = rst_n && ((state_q == S_IDLE) || ((state_q == S_HOLD) && rsp_hs));
        fetch_first = if_req_valid && (!dm_req_valid || (starve_q >= STARVE_LIM));
        pick_if  = slot && fetch_first;
        pick_dm  = slot && dm_req_valid && !fetch_first;
        accept   = pick_if || pick_dm;
        win_addr = pick_dm ? dm_req_addr : if_req_addr;

        if_req_ready = pick_if;
        dm_req_ready = pick_dm;
        mem_en       = accept && !win_addr[0];
        mem_addr     = mem_en ? win_addr : 32'd0;

        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_READ;
            end
            S_READ: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = misal_q ? 32'd0 : mem_rdata;
                rsp_err_d   = misal_q;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (rsp_hs) begin
                    rsp_valid_d = 1'b0;
                    state_d     = accept ? S_READ : S_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase

        if (accept) begin
            grant_d = pick_dm;
            misal_d = win_addr[0];
        end

        // Counts data grants taken while fetch sits waiting; saturates.
        if (!if_req_valid || pick_if) begin
            starve_d = '0;
        end else if (pick_dm && (starve_q < STARVE_LIM)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    assign grant_dm     = grant_q;
    assign if_rsp_valid = rsp_valid_q && !grant_q;
    assign dm_rsp_valid = rsp_valid_q && grant_q;
    assign if_rsp_data  = if_rsp_valid ? rsp_data_q : 32'd0;
    assign dm_rsp_data  = dm_rsp_valid ? rsp_data_q : 32'd0;
    assign if_rsp_err   = if_rsp_valid && rsp_err_q;
    assign dm_rsp_err   = dm_rsp_valid && rsp_err_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Testbench for imem_arbiter. Each table row describes one clock cycle:
// the inputs driven in that cycle, and the outputs expected in the same cycle.
// Hand-written sequences cover starvation, mid-read reset, and the initial
// reset state.
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_valid, if_req_ready;
    logic [31:0] if_req_addr;
    logic        if_rsp_valid, if_rsp_ready;
    logic [31:0] if_rsp_data;
    logic        if_rsp_err;
    logic        dm_req_valid, dm_req_ready;
    logic [31:0] dm_req_addr;
    logic        dm_rsp_valid, dm_rsp_ready;
    logic [31:0] dm_rsp_data;
    logic        dm_rsp_err;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        grant_dm;

    int n_checks = 0;
    int n_errors = 0;

    imem_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready),
        .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
        .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_req_addr(dm_req_addr),
        .dm_rsp_valid(dm_rsp_valid), .dm_rsp_ready(dm_rsp_ready),
        .dm_rsp_data(dm_rsp_data), .dm_rsp_err(dm_rsp_err),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .grant_dm(grant_dm)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        ifv;
        logic [31:0] ifa;
        logic        dmv;
        logic [31:0] dma;
        logic        ifr;
        logic        dmr;
        logic [31:0] rd;
        logic        e_ifrdy;
        logic        e_dmrdy;
        logic        e_men;
        logic [31:0] e_maddr;
        logic        e_gdm;
        logic        e_ifv;
        logic        e_dmv;
        logic [31:0] e_data;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(
        input logic ifv, input logic [31:0] ifa, input logic dmv, input logic [31:0] dma,
        input logic ifr, input logic dmr, input logic [31:0] rd,
        input logic e_ifrdy, input logic e_dmrdy, input logic e_men, input logic [31:0] e_maddr,
        input logic e_gdm, input logic e_ifv, input logic e_dmv, input logic [31:0] e_data,
        input logic e_err);
        vec_t v;
        v.ifv = ifv; v.ifa = ifa; v.dmv = dmv; v.dma = dma;
        v.ifr = ifr; v.dmr = dmr; v.rd = rd;
        v.e_ifrdy = e_ifrdy; v.e_dmrdy = e_dmrdy; v.e_men = e_men; v.e_maddr = e_maddr;
        v.e_gdm = e_gdm; v.e_ifv = e_ifv; v.e_dmv = e_dmv; v.e_data = e_data; v.e_err = e_err;
        return v;
    endfunction

    // {if_rdy, dm_rdy, mem_en, mem_addr, grant_dm, if_rsp v/data/err, dm_rsp v/data/err}
    function automatic logic [103:0] outs();
        return {if_req_ready, dm_req_ready, mem_en, mem_addr, grant_dm,
                if_rsp_valid, if_rsp_data, if_rsp_err,
                dm_rsp_valid, dm_rsp_data, dm_rsp_err};
    endfunction

    function automatic logic [103:0] exp_outs(input vec_t v);
        return {v.e_ifrdy, v.e_dmrdy, v.e_men, v.e_maddr, v.e_gdm,
                v.e_ifv, (v.e_ifv ? v.e_data : 32'd0), (v.e_ifv & v.e_err),
                v.e_dmv, (v.e_dmv ? v.e_data : 32'd0), (v.e_dmv & v.e_err)};
    endfunction

    task automatic chk(input string name, input logic [103:0] act, input logic [103:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        if_req_valid = 1'b0; if_req_addr = 32'd0;
        dm_req_valid = 1'b0; dm_req_addr = 32'd0;
        if_rsp_ready = 1'b0; dm_rsp_ready = 1'b0;
        mem_rdata    = 32'd0;
    endtask

    initial begin
        logic        gw[$];
        int          gc[$];
        logic        saw_rsp;
        logic        saw_men;
        int          cyc;

        // Single fetch 0x10
        vecs.push_back(mkv(0,0,0,0,0,0,0,                      0,0,0,0,0,0,0,0,0));
        vecs.push_back(mkv(1,32'h10,0,0,0,0,0,                 1,0,1,32'h10,0,0,0,0,0));
        vecs.push_back(mkv(0,0,0,0,0,0,32'hDEADBEEF,           0,0,0,0,0,0,0,0,0));
        vecs.push_back(mkv(0,0,0,0,0,0,0,                      0,0,0,0,0,1,0,32'hDEADBEEF,0));
        vecs.push_back(mkv(0,0,0,0,1,0,0,                      0,0,0,0,0,1,0,32'hDEADBEEF,0));
        vecs.push_back(mkv(0,0,0,0,0,0,0,                      0,0,0,0,0,0,0,0,0));
        // Simultaneous fetch 0x20 / data 0x40: data first, fetch in the HOLD handshake slot
        vecs.push_back(mkv(1,32'h20,1,32'h40,1,1,0,            0,1,1,32'h40,0,0,0,0,0));
        vecs.push_back(mkv(1,32'h20,0,0,1,1,32'h11111111,      0,0,0,0,1,0,0,0,0));
        vecs.push_back(mkv(1,32'h20,0,0,1,1,0,                 1,0,1,32'h20,1,0,1,32'h11111111,0));
        vecs.push_back(mkv(0,0,0,0,1,1,32'h22222222,           0,0,0,0,0,0,0,0,0));
        vecs.push_back(mkv(0,0,0,0,1,0,0,                      0,0,0,0,0,1,0,32'h22222222,0));
        vecs.push_back(mkv(0,0,0,0,0,0,0,                      0,0,0,0,0,0,0,0,0));
        // Misaligned data 0x41: no ROM access, err=1 data 0
        vecs.push_back(mkv(0,0,1,32'h41,0,0,0,                 0,1,0,0,0,0,0,0,0));
        vecs.push_back(mkv(0,0,0,0,0,0,32'hFFFFFFFF,           0,0,0,0,1,0,0,0,0));
        vecs.push_back(mkv(0,0,0,0,0,0,32'hFFFFFFFF,           0,0,0,0,1,0,1,0,1));
        vecs.push_back(mkv(0,0,0,0,0,1,0,                      0,0,0,0,1,0,1,0,1));
        vecs.push_back(mkv(0,0,0,0,0,0,0,                      0,0,0,0,1,0,0,0,0));
        // Back-pressure on data response for 5 cycles with fetch queued
        vecs.push_back(mkv(0,0,1,32'h80,0,0,0,                 0,1,1,32'h80,1,0,0,0,0));
        vecs.push_back(mkv(1,32'h84,0,0,0,0,32'hCAFEF00D,      0,0,0,0,1,0,0,0,0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mkv(1,32'h84,0,0,0,0,32'h12345678,  0,0,0,0,1,0,1,32'hCAFEF00D,0));
        vecs.push_back(mkv(1,32'h84,0,0,0,1,0,                 1,0,1,32'h84,1,0,1,32'hCAFEF00D,0));
        vecs.push_back(mkv(0,0,0,0,0,0,32'h0BADCAFE,           0,0,0,0,0,0,0,0,0));
        vecs.push_back(mkv(0,0,0,0,1,0,0,                      0,0,0,0,0,1,0,32'h0BADCAFE,0));
        vecs.push_back(mkv(0,0,0,0,0,0,0,                      0,0,0,0,0,0,0,0,0));

        // Reset state with requests pending: everything must read 0
        rst_n = 1'b0;
        drive_idle();
        if_req_valid = 1'b1; if_req_addr = 32'h10;
        dm_req_valid = 1'b1; dm_req_addr = 32'h40;
        #12;
        chk("reset_outputs", outs(), 104'd0);
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk);
            #2;
            if_req_valid = vecs[i].ifv; if_req_addr = vecs[i].ifa;
            dm_req_valid = vecs[i].dmv; dm_req_addr = vecs[i].dma;
            if_rsp_ready = vecs[i].ifr; dm_rsp_ready = vecs[i].dmr;
            mem_rdata    = vecs[i].rd;
            @(negedge clk);
            chk($sformatf("vec%0d", i), outs(), exp_outs(vecs[i]));
        end

        // Starvation: data held valid with fetch pending -> 4 data grants, then fetch
        @(posedge clk);
        #2;
        dm_req_valid = 1'b1; dm_req_addr = 32'h100;
        if_req_valid = 1'b1; if_req_addr = 32'h200;
        if_rsp_ready = 1'b1; dm_rsp_ready = 1'b1;
        mem_rdata    = 32'h5;
        cyc = 0;
        while (gw.size() < 5 && cyc < 30) begin
            @(negedge clk);
            if (if_req_ready || dm_req_ready) begin
                gw.push_back(dm_req_ready);
                gc.push_back(cyc);
            end
            cyc++;
        end
        @(posedge clk);
        #2;
        drive_idle();
        if_rsp_ready = 1'b1; dm_rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < gw.size())
                chk($sformatf("starve_grant%0d", i), {103'd0, gw[i]}, {103'd0, (i < 4)});
            else
                chk($sformatf("starve_grant%0d_missing", i), 104'd1, 104'd0);
        end
        for (int i = 1; i < gc.size(); i++)
            chk($sformatf("starve_spacing%0d", i), 104'(gc[i] - gc[i-1]), 104'd2);
        repeat (4) @(posedge clk);

        // Reset while in READ: outputs drop at once, no response after release
        #2;
        drive_idle();
        dm_req_valid = 1'b1; dm_req_addr = 32'h300;
        @(negedge clk);
        chk("rst_mid_accept", {102'd0, dm_req_ready, mem_en}, {102'd0, 2'b11});
        @(posedge clk);
        #2;
        dm_req_valid = 1'b0; dm_req_addr = 32'd0;
        if_req_valid = 1'b1; if_req_addr = 32'h400;
        dm_rsp_ready = 1'b1; if_rsp_ready = 1'b1;
        mem_rdata    = 32'hA5A5A5A5;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", outs(), 104'd0);
        @(negedge clk);
        if_req_valid = 1'b0; if_req_addr = 32'd0;
        #1;
        rst_n = 1'b1;
        saw_rsp = 1'b0;
        saw_men = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (if_rsp_valid || dm_rsp_valid) saw_rsp = 1'b1;
            if (mem_en) saw_men = 1'b1;
        end
        chk("rst_mid_no_rsp", {103'd0, saw_rsp}, 104'd0);
        chk("rst_mid_no_mem_en", {103'd0, saw_men}, 104'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 The block SHALL take one parameter: STARVE_MAX, default 4, the maximum number of consecutive data grants while fetch is waiting.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have ports if_req_valid (in, 1), if_req_ready (out, 1) and if_req_addr (in, 32): the fetch request channel.
REQ-005 The block SHALL have ports if_rsp_valid (out, 1), if_rsp_ready (in, 1), if_rsp_data (out, 32) and if_rsp_err (out, 1): the fetch response channel.
REQ-006 The block SHALL have ports dm_req_valid (in, 1), dm_req_ready (out, 1) and dm_req_addr (in, 32): the data-side ROM read request channel.
REQ-007 The block SHALL have ports dm_rsp_valid (out, 1), dm_rsp_ready (in, 1), dm_rsp_data (out, 32) and dm_rsp_err (out, 1): the data-side response channel.
REQ-008 The block SHALL have ports mem_en (out, 1), mem_addr (out, 32) and mem_rdata (in, 32): the single shared synchronous ROM read port; mem_rdata is valid the cycle after mem_en.
REQ-009 The block SHALL have port grant_dm (out, 1): the owner of the transaction in flight (1 = data, 0 = fetch).

Function
REQ-010 The block SHALL implement an FSM with three states.
- IDLE: no transaction.
- READ: ROM access issued, data returns this cycle.
- HOLD: response valid, waiting for consumer.
REQ-011 A request SHALL be accepted only in IDLE, or in HOLD in the same cycle the current response handshakes (rsp_valid && rsp_ready).
REQ-012 Acceptance SHALL be signalled by the combinational req_ready of the winner; the loser's req_ready SHALL be 0; valid/ready are a standard handshake, and requesters hold valid and addr stable until ready.
REQ-013 Arbitration SHALL give data priority, unless fetch has been valid-and-not-granted across STARVE_MAX consecutive data grants; then fetch SHALL win the next grant.
REQ-014 The starvation counter SHALL clear when fetch is granted or if_req_valid is 0, and SHALL saturate at STARVE_MAX.
REQ-015 On acceptance with addr[0]=0, the block SHALL drive mem_en=1 and mem_addr=winner addr in that cycle, latch the owner into grant_dm, and go to READ.
REQ-016 On acceptance with addr[0]=1, the block SHALL keep mem_en=0 and go to READ, and the response SHALL carry data 0 and err=1.
REQ-017 In READ, the block SHALL register mem_rdata (or 0 for a misaligned access) into the owner's rsp_data, set the owner's rsp_valid and err, and go to HOLD.
REQ-018 Latency SHALL be: accept at cycle T gives rsp_valid high from cycle T+2; sustained throughput is one transaction per 2 cycles.
REQ-019 In HOLD, rsp_valid/data/err SHALL stay stable until rsp_ready.
- On handshake with no new accept: rsp_valid drops and the state returns to IDLE.
- On handshake with a new accept: the state goes to READ.
REQ-020 Only one transaction SHALL be outstanding; the non-owner's rsp_valid SHALL be 0.
REQ-021 mem_en SHALL be 0 in READ and in HOLD, except in a HOLD-handshake accept cycle.
REQ-022 The block SHALL pass the address to mem_addr unmodified; 32-bit assembly from halfwords belongs to the ROM.

Reset
REQ-023 While rst_n=0, the block SHALL force the FSM to IDLE and clear the starvation counter.
REQ-024 While rst_n=0, the block SHALL drive all rsp_valid, rsp_data, rsp_err, mem_en, mem_addr, grant_dm and req_ready outputs to 0.
REQ-025 A reset mid-transaction SHALL discard the in-flight read; no response is produced after rst_n deassertion.

Verification
REQ-026 Single fetch: if_req addr 0x10 with mem_rdata 0xDEADBEEF -> mem_en at T, if_rsp_valid at T+2, data 0xDEADBEEF, err 0.
REQ-027 Simultaneous requests (if 0x20, dm 0x40) -> dm granted first; fetch granted on the next accept slot.
REQ-028 Fetch starvation: dm_req_valid held high with fetch pending, STARVE_MAX=4 -> 4 data grants, then a fetch grant.
REQ-029 Back-pressure: dm_rsp_ready held 0 for 5 cycles -> dm_rsp_data stable and no new mem_en; on ready, a queued fetch is accepted in the same cycle.
REQ-030 Misaligned dm addr 0x41 -> no mem_en, dm_rsp_err=1 and data 0 at T+2.
REQ-031 Assert rst_n=0 in the READ state -> all outputs 0 immediately; no response after release.
